// File: rtl/apb_periph_endpoint.sv
// APB endpoint register file (APB_EP_RAND_WAIT_EN adds LFSR-jittered wait states).
// Latency: GRANT_e_p pulses WAIT_CYCLES(+jitter)+1 cycles after the request is captured.
// Backpressure: REQ_p_e is a held level; a new request is accepted only after REQ_p_e drops post-grant.
`timescale 1ns/1ps

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module apb_periph_endpoint #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic                   PCLK,
    input  logic                   PRESET,
    input  logic [`ADDR_WIDTH-1:0] ADDR_p_e,
    input  logic                   WRITE_p_e,
    input  logic [`DATA_WIDTH-1:0] WDATA_p_e,
    input  logic                   REQ_p_e,
    output logic                   GRANT_e_p,
    output logic [`DATA_WIDTH-1:0] RDATA_e_p,
    output logic [`ADDR_WIDTH-1:0] MaxAddr
);

    localparam int AW = `ADDR_WIDTH;
    localparam int DW = `DATA_WIDTH;
    localparam int IW = $clog2(DEPTH);
    localparam int CW = 5;
    localparam logic [AW-1:0] MAX_ADDR = AW'(DEPTH - 1);

    if (LFSR_SEED == 8'd0 || WAIT_CYCLES > 15) begin : g_param_err
        $error("apb_periph_endpoint: LFSR_SEED must be nonzero and WAIT_CYCLES <= 15");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_GRANT,
        ST_RELEASE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            write_q, write_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            grant_q, grant_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [DW-1:0]   mem_q [DEPTH];

    logic [CW-1:0]   wait_total;
    logic            in_range;
    logic [IW-1:0]   idx;
    logic            do_access;

    assign MaxAddr   = MAX_ADDR;
    assign GRANT_e_p = grant_q;
    assign RDATA_e_p = rdata_q;

    assign in_range  = (addr_q <= MAX_ADDR);
    assign idx       = addr_q[IW-1:0];
    // The access is performed on the edge that leaves GRANT, which is also the edge raising GRANT_e_p.
    assign do_access = (state_q == ST_GRANT);

`ifdef APB_EP_RAND_WAIT_EN
    logic [7:0] lfsr_q, lfsr_d;

    assign lfsr_d     = do_access ? {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]}
                                  : lfsr_q;
    assign wait_total = CW'(WAIT_CYCLES) + CW'(lfsr_q[1:0]);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign wait_total = CW'(WAIT_CYCLES);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (REQ_p_e) begin
                    addr_d  = ADDR_p_e;
                    write_d = WRITE_p_e;
                    wdata_d = WDATA_p_e;
                    if (wait_total == '0) begin
                        state_d = ST_GRANT;
                    end else begin
                        cnt_d   = wait_total - CW'(1);
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_GRANT;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_GRANT: begin
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!REQ_p_e) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        grant_d = do_access;
        rdata_d = rdata_q;
        if (do_access && !write_q) begin
            rdata_d = in_range ? mem_q[idx] : '0;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            grant_q <= 1'b0;
            rdata_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            grant_q <= grant_d;
            rdata_q <= rdata_d;
            if (do_access && write_q && in_range) begin
                mem_q[idx] <= wdata_q;
            end
        end
    end

endmodule

// File: tb/tb_apb_periph_endpoint.sv
// Scoreboard bench: two endpoints (WAIT_CYCLES=2 and 0) share one request stream.
// Expected grant cycle and read data come from an array/queue model of the register file.
`timescale 1ns/1ps

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_apb_periph_endpoint;

    localparam int DEPTH = 16;
    localparam int AW    = `ADDR_WIDTH;
    localparam int DW    = `DATA_WIDTH;
    localparam int W_A   = 2;
    localparam int W_B   = 0;
    localparam logic [7:0] SEED = 8'hA5;

    typedef struct {
        int            due;
        logic          is_rd;
        logic [DW-1:0] data;
    } exp_t;

    logic          PCLK   = 1'b0;
    logic          PRESET = 1'b1;
    logic [AW-1:0] addr   = '0;
    logic          wr     = 1'b0;
    logic [DW-1:0] wdata  = '0;
    logic          req    = 1'b0;
    logic          grant_a, grant_b;
    logic [DW-1:0] rdata_a, rdata_b;
    logic [AW-1:0] max_a, max_b;

    int n_cmp  = 0;
    int n_err  = 0;
    int cyc    = 0;
    int gcnt_a = 0;
    int gcnt_b = 0;

    exp_t          q_a[$];
    exp_t          q_b[$];
    logic [DW-1:0] mem_m [DEPTH];
    logic [7:0]    lfsr_m;

    apb_periph_endpoint #(.DEPTH(DEPTH), .WAIT_CYCLES(W_A), .LFSR_SEED(SEED)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .ADDR_p_e(addr), .WRITE_p_e(wr), .WDATA_p_e(wdata),
        .REQ_p_e(req), .GRANT_e_p(grant_a), .RDATA_e_p(rdata_a), .MaxAddr(max_a)
    );

    apb_periph_endpoint #(.DEPTH(DEPTH), .WAIT_CYCLES(W_B), .LFSR_SEED(SEED)) dut_w0 (
        .PCLK(PCLK), .PRESET(PRESET), .ADDR_p_e(addr), .WRITE_p_e(wr), .WDATA_p_e(wdata),
        .REQ_p_e(req), .GRANT_e_p(grant_b), .RDATA_e_p(rdata_b), .MaxAddr(max_b)
    );

    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) cyc <= cyc + 1;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req_v);
        n_cmp++;
        if (act !== req_v) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req_v);
        end
    endtask

    task automatic check_exp(input string nm, input exp_t e, input logic [DW-1:0] rd);
        n_cmp++;
        if (cyc != e.due) begin
            n_err++;
            $display("FAIL latency_%s: grant at cycle %0d, required cycle %0d", nm, cyc, e.due);
        end
        if (e.is_rd) begin
            n_cmp++;
            if (rd !== e.data) begin
                n_err++;
                $display("FAIL rdata_%s: got %0h, required %0h (cycle %0d)", nm, rd, e.data, cyc);
            end
        end
    endtask

    // Monitor: every grant pulse must match the oldest outstanding expectation.
    always @(negedge PCLK) begin
        exp_t e;
        if (!PRESET) begin
            if (grant_a) begin
                gcnt_a++;
                if (q_a.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL spurious_grant_a: grant at cycle %0d, required none", cyc);
                end else begin
                    e = q_a.pop_front();
                    check_exp("a", e, rdata_a);
                end
            end
            if (grant_b) begin
                gcnt_b++;
                if (q_b.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL spurious_grant_b: grant at cycle %0d, required none", cyc);
                end else begin
                    e = q_b.pop_front();
                    check_exp("b", e, rdata_b);
                end
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        lfsr_m = SEED;
        q_a.delete();
        q_b.delete();
    endtask

    // mode 0: REQ pulsed for one cycle; 1: held until grant; 2: held 'extra' cycles beyond grant.
    task automatic do_txn(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                          input int mode, input int extra);
        exp_t ea, eb;
        int   ai, e0, jit, ga, gb, t;
        ai  = int'(a);
        jit = 0;
`ifdef APB_EP_RAND_WAIT_EN
        jit    = int'(lfsr_m[1:0]);
        lfsr_m = lfsr_next(lfsr_m);
`endif
        e0       = cyc + 1;
        ea.due   = e0 + 1 + W_A + jit;
        eb.due   = e0 + 1 + W_B + jit;
        ea.is_rd = !w;
        ea.data  = '0;
        if (w) begin
            if (ai < DEPTH) mem_m[ai] = d;
        end else if (ai < DEPTH) begin
            ea.data = mem_m[ai];
        end
        eb.is_rd = ea.is_rd;
        eb.data  = ea.data;
        q_a.push_back(ea);
        q_b.push_back(eb);
        ga    = gcnt_a;
        gb    = gcnt_b;
        addr  = a;
        wr    = w;
        wdata = d;
        req   = 1'b1;
        if (mode == 0) begin
            @(negedge PCLK);
            req   = 1'b0;
            addr  = AW'($urandom);
            wdata = DW'($urandom);
            wr    = 1'($urandom);
        end
        t = 0;
        while ((gcnt_a == ga || gcnt_b == gb) && t < 60) begin
            @(negedge PCLK);
            t++;
        end
        if (t >= 60) begin
            n_cmp++;
            n_err++;
            $display("FAIL grant_timeout: grants a=%0d b=%0d, required one each", gcnt_a - ga, gcnt_b - gb);
        end
        if (mode == 2) repeat (extra) @(negedge PCLK);
        req = 1'b0;
        @(negedge PCLK);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge PCLK);
        chk("rst_grant_a", 64'(grant_a), 64'd0);
        chk("rst_grant_b", 64'(grant_b), 64'd0);
        chk("rst_rdata_a", 64'(rdata_a), 64'd0);
        chk("rst_rdata_b", 64'(rdata_b), 64'd0);
        chk("maxaddr_a", 64'(max_a), 64'(DEPTH - 1));
        chk("maxaddr_b", 64'(max_b), 64'(DEPTH - 1));
        PRESET = 1'b0;
        @(negedge PCLK);

        do_txn(AW'(3), 1'b1, DW'(32'hDEADBEEF), 1, 0);
        do_txn(AW'(3), 1'b0, '0, 1, 0);
        do_txn(AW'(20), 1'b0, '0, 1, 0);
        do_txn(AW'(20), 1'b1, DW'(32'h12345678), 1, 0);
        for (int i = 0; i < DEPTH; i++) do_txn(AW'(i), 1'b0, '0, int'($urandom_range(0, 2)), 1);
        do_txn(AW'(3), 1'b0, '0, 2, 4);
        do_txn(AW'(DEPTH), 1'b1, DW'(32'h0BAD0BAD), 0, 0);
        do_txn(AW'(DEPTH - 1), 1'b1, DW'(32'h600DF00D), 0, 0);
        do_txn(AW'(DEPTH - 1), 1'b0, '0, 0, 0);

        for (int n = 0; n < 150; n++) begin
            do_txn(AW'($urandom_range(0, DEPTH + 7)), 1'($urandom), DW'($urandom),
                   int'($urandom_range(0, 2)), int'($urandom_range(1, 3)));
        end
        for (int i = 0; i < 4; i++) do_txn(AW'(7), 1'b1, DW'($urandom), 1, 0);

        // Write to 7 aborted by reset while the W=2 endpoint is waiting.
        addr  = AW'(7);
        wr    = 1'b1;
        wdata = DW'(32'hCAFEF00D);
        req   = 1'b1;
        @(posedge PCLK);
        #2;
        PRESET = 1'b1;
        req    = 1'b0;
        model_reset();
        #1;
        chk("midrst_grant_a", 64'(grant_a), 64'd0);
        chk("midrst_grant_b", 64'(grant_b), 64'd0);
        chk("midrst_rdata_a", 64'(rdata_a), 64'd0);
        chk("midrst_rdata_b", 64'(rdata_b), 64'd0);
        repeat (3) @(negedge PCLK);
        PRESET = 1'b0;
        @(negedge PCLK);
        for (int i = 0; i < DEPTH; i++) do_txn(AW'(i), 1'b0, '0, 1, 0);
        do_txn(AW'(7), 1'b1, DW'(32'hA5A5_5A5A), 1, 0);
        do_txn(AW'(7), 1'b0, '0, 0, 0);

        repeat (10) @(negedge PCLK);
        chk("drain_a", 64'(q_a.size()), 64'd0);
        chk("drain_b", 64'(q_b.size()), 64'd0);
        chk("maxaddr_end", 64'(max_a), 64'(DEPTH - 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
